// File: rtl/half_adder_pkg.sv
// Shared constants and width helper for the registered multi-lane half adder.
package half_adder_pkg;

  localparam int unsigned HA_DEFAULT_WIDTH = 1;
  localparam int unsigned HA_MAX_WIDTH     = 64;

  // Bits needed to hold a lane count in 0..width inclusive.
  function automatic int unsigned carry_count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single combinational half-adder lane: one-bit sum and carry.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b;
  assign carry_out = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered WIDTH-lane half adder with a valid qualifier and one-cycle latency.
// Optional HALF_ADDER_CARRY_COUNT_EN adds a registered popcount of the carry lanes.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = HA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry_out
`ifdef HALF_ADDER_CARRY_COUNT_EN
  ,
  output logic [carry_count_width(WIDTH)-1:0] carry_count
`endif
);

  if (WIDTH < 1 || WIDTH > HA_MAX_WIDTH) begin : g_bad_width
    $error("half_adder: WIDTH out of range");
  end

  logic [WIDTH-1:0] sum_w, carry_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a         (a[i]),
      .b         (b[i]),
      .sum       (sum_w[i]),
      .carry_out (carry_w[i])
    );
  end

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic [WIDTH-1:0] carry_d, carry_q;

`ifdef HALF_ADDER_CARRY_COUNT_EN
  localparam int unsigned CntW = carry_count_width(WIDTH);

  logic [CntW-1:0] cnt_w, cnt_d, cnt_q;

  always_comb begin
    cnt_w = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_w = cnt_w + CntW'(carry_w[i]);
    end
    cnt_d = in_valid ? cnt_w : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_count = cnt_q;
`endif

  // Data registers only load on accepted inputs, so X on idle inputs never reaches them.
  always_comb begin
    out_valid_d = in_valid;
    sum_d       = in_valid ? sum_w   : sum_q;
    carry_d     = in_valid ? carry_w : carry_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: WIDTH=1 and WIDTH=8 instances against a lane-arithmetic reference model.
module tb_half_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv1, iv8;
  logic [0:0] a1, b1;
  logic [7:0] a8, b8;
  logic       ov1, ov8;
  logic [0:0] s1, c1;
  logic [7:0] s8, c8;
`ifdef HALF_ADDER_CARRY_COUNT_EN
  logic [0:0] cc1;
  logic [3:0] cc8;
`endif

  half_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv1),
    .a         (a1),
    .b         (b1),
    .out_valid (ov1),
    .sum       (s1),
    .carry_out (c1)
`ifdef HALF_ADDER_CARRY_COUNT_EN
    ,
    .carry_count (cc1)
`endif
  );

  half_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .a         (a8),
    .b         (b8),
    .out_valid (ov8),
    .sum       (s8),
    .carry_out (c8)
`ifdef HALF_ADDER_CARRY_COUNT_EN
    ,
    .carry_count (cc8)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference state: what each output should show after the latest edge.
  logic       m1_v, m8_v;
  logic [0:0] m1_s, m1_c;
  logic [7:0] m8_s, m8_c;
  int         m1_cnt, m8_cnt;

  // Drive one cycle of stimulus, advance past the edge and update the model.
  task automatic cycle(input logic r, input logic v1, input logic [0:0] x1, input logic [0:0] y1,
                       input logic v8, input logic [7:0] x8, input logic [7:0] y8);
    rst = r; iv1 = v1; a1 = x1; b1 = y1; iv8 = v8; a8 = x8; b8 = y8;
    @(posedge clk);
    if (r) begin
      m1_v = 0; m1_s = '0; m1_c = '0; m1_cnt = 0;
      m8_v = 0; m8_s = '0; m8_c = '0; m8_cnt = 0;
    end else begin
      m1_v = v1;
      if (v1) begin
        int t;
        t = int'(x1[0]) + int'(y1[0]);
        m1_s[0] = (t % 2) == 1;
        m1_c[0] = t >= 2;
        m1_cnt  = t / 2;
      end
      m8_v = v8;
      if (v8) begin
        m8_cnt = 0;
        for (int i = 0; i < 8; i++) begin
          int t;
          t = int'(x8[i]) + int'(y8[i]);
          m8_s[i] = (t % 2) == 1;
          m8_c[i] = t >= 2;
          m8_cnt += t / 2;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
      total++;
      if ({ov1, s1, c1} !== 3'b000) begin
        bad++;
        $display("FAIL reset_w1[%0d]: got v=%b s=%b c=%b want all 0", k, ov1, s1, c1);
      end
      total++;
      if ({ov8, s8, c8} !== 17'd0) begin
        bad++;
        $display("FAIL reset_w8[%0d]: got v=%b s=%h c=%h want all 0", k, ov8, s8, c8);
      end
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] av [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
    logic [1:0] bv [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
    logic [1:0] want [4] = '{2'b00, 2'b10, 2'b01, 2'b00};
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, av[k][0], bv[k][0], 1'b0, 8'h00, 8'h00);
      total++;
      if ({ov1, s1, c1} !== {1'b1, want[k]} || {s1, c1} !== {m1_s, m1_c}) begin
        bad++;
        $display("FAIL truth_w1[%0d]: got v=%b s=%b c=%b want v=1 s=%b c=%b",
                 k, ov1, s1, c1, want[k][1], want[k][0]);
      end
    end
  endtask

  task automatic test_hold();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h0F);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hxx, 8'hxx);
    total++;
    if ({ov1, s1, c1} !== 3'b001) begin
      bad++;
      $display("FAIL hold_w1: got v=%b s=%b c=%b want v=0 s=0 c=1", ov1, s1, c1);
    end
    total++;
    if ({ov8, s8, c8} !== {1'b0, 8'hAA, 8'h05}) begin
      bad++;
      $display("FAIL hold_x_w8: got v=%b s=%h c=%h want v=0 s=aa c=05", ov8, s8, c8);
    end
  endtask

  task automatic test_width8();
    logic [7:0] av [2] = '{8'hF0, 8'hFF};
    logic [7:0] bv [2] = '{8'h3C, 8'hFF};
    logic [7:0] ws [2] = '{8'hCC, 8'h00};
    logic [7:0] wc [2] = '{8'h30, 8'hFF};
`ifdef HALF_ADDER_CARRY_COUNT_EN
    logic [3:0] wn [2] = '{4'd2, 4'd8};
`endif
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, av[k], bv[k]);
      total++;
      if ({ov8, s8, c8} !== {1'b1, ws[k], wc[k]}) begin
        bad++;
        $display("FAIL vec_w8[%0d]: got v=%b s=%h c=%h want v=1 s=%h c=%h",
                 k, ov8, s8, c8, ws[k], wc[k]);
      end
`ifdef HALF_ADDER_CARRY_COUNT_EN
      total++;
      if (cc8 !== wn[k]) begin
        bad++;
        $display("FAIL count_w8[%0d]: got %0d want %0d", k, cc8, wn[k]);
      end
`endif
    end
  endtask

  task automatic test_midstream_reset();
    logic [7:0] av [4] = '{8'h12, 8'hF3, 8'h77, 8'hC6};
    logic [7:0] bv [4] = '{8'h34, 8'h3F, 8'h77, 8'h5A};
    for (int k = 0; k < 4; k++) begin
      cycle(k == 2, 1'b1, av[k][0], bv[k][0], 1'b1, av[k], bv[k]);
      total++;
      if ({ov8, s8, c8} !== {m8_v, m8_s, m8_c} || (k == 2 && {ov8, s8, c8} !== 17'd0)) begin
        bad++;
        $display("FAIL midrst_w8[%0d]: got v=%b s=%h c=%h want v=%b s=%h c=%h",
                 k, ov8, s8, c8, m8_v, m8_s, m8_c);
      end
      total++;
      if ({ov1, s1, c1} !== {m1_v, m1_s, m1_c}) begin
        bad++;
        $display("FAIL midrst_w1[%0d]: got v=%b s=%b c=%b want v=%b s=%b c=%b",
                 k, ov1, s1, c1, m1_v, m1_s, m1_c);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [7:0] x8, y8;
      logic       v1, v8;
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      v1 = ($urandom_range(0, 3) != 0);
      v8 = ($urandom_range(0, 3) != 0);
      cycle($urandom_range(0, 19) == 0, v1, 1'($urandom), 1'($urandom), v8,
            v8 ? x8 : 8'hxx, v8 ? y8 : 8'hxx);
      total++;
      if ({ov1, s1, c1} !== {m1_v, m1_s, m1_c}) begin
        bad++;
        $display("FAIL rand_w1[%0d]: got v=%b s=%b c=%b want v=%b s=%b c=%b",
                 n, ov1, s1, c1, m1_v, m1_s, m1_c);
      end
      total++;
      if ({ov8, s8, c8} !== {m8_v, m8_s, m8_c}) begin
        bad++;
        $display("FAIL rand_w8[%0d]: got v=%b s=%h c=%h want v=%b s=%h c=%h",
                 n, ov8, s8, c8, m8_v, m8_s, m8_c);
      end
`ifdef HALF_ADDER_CARRY_COUNT_EN
      total++;
      if (int'(cc8) != m8_cnt || int'(cc1) != m1_cnt) begin
        bad++;
        $display("FAIL rand_count[%0d]: got w8=%0d w1=%0d want w8=%0d w1=%0d",
                 n, cc8, cc1, m8_cnt, m1_cnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_width8();
    test_midstream_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
